game_flow_ctrl: RTL

Top-level game sequencer that drives the text/splash overlay and the run timer. It turns player buttons and playfield events (crash, finish line) into one state machine. From that state it produces the overlay selects start_en, crash_en and finish_en, the timer controls pause and reset_game, and the latched finish time shown on the finish screen. It sits between the input/collision logic and the text overlay and timer blocks.

---
 rtl/game_flow_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//
// Top-level game sequencer. Turns player buttons and playfield events into a
// single state machine and decodes that state into overlay selects, timer
// controls and the latched finish time.
//
// Ports
//   clk          system pixel clock, all logic on rising edge
//   reset        synchronous, active-high reset
//   start_btn    start button level (debounced externally)
//   pause_btn    pause button level (debounced externally)
//   crash_det    collision detected (level or pulse)
//   finish_det   finish line reached (level or pulse)
//   second_tick  one-cycle pulse once per second from the timer
//   run_time     current timer value (BCD-packed, passed through untouched)
//   start_en     start splash select   (state == IDLE)
//   crash_en     crash splash select   (state == CRASH)
//   finish_en    finish splash select  (state == FINISH)
//   pause        timer freeze, low only while running
//   reset_game   one-cycle timer/game clear on IDLE->RUN, high during reset
//   finish_time  run_time captured on the RUN->FINISH edge
//   state        current state code, for debug
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
  parameter int unsigned CRASH_HOLD_S = 3,
  parameter int unsigned TIME_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              pause_btn,
  input  logic              crash_det,
  input  logic              finish_det,
  input  logic              second_tick,
  input  logic [TIME_W-1:0] run_time,
  output logic              start_en,
  output logic              crash_en,
  output logic              finish_en,
  output logic              pause,
  output logic              reset_game,
  output logic [TIME_W-1:0] finish_time,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_CRASH  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Count value at which the next second_tick ends the crash screen.
  localparam logic [3:0] HOLD_LAST = 4'(CRASH_HOLD_S - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_start_q;
  logic              r_pause_q;
  logic [3:0]        r_hold_cnt;
  logic              r_reset_game;
  logic [TIME_W-1:0] r_finish_time;

  logic              w_start_edge;
  logic              w_pause_edge;
  logic              w_enter_run;
  logic              w_enter_crash;
  logic              w_enter_finish;

  // Previous-value registers reset to 1, so a button held through reset
  // must be released and pressed again before it counts as an edge.
  assign w_start_edge = start_btn & ~r_start_q;
  assign w_pause_edge = pause_btn & ~r_pause_q;

  // Next-state logic; priority within each state is top-down.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state -> no latch.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (crash_det)         w_next_state = ST_CRASH;
        else if (finish_det)   w_next_state = ST_FINISH;
        else if (w_pause_edge) w_next_state = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (w_pause_edge) w_next_state = ST_RUN;
      end
      ST_CRASH: begin
        if (w_start_edge)                                 w_next_state = ST_IDLE;
        else if (second_tick && (r_hold_cnt == HOLD_LAST)) w_next_state = ST_IDLE;
      end
      ST_FINISH: begin
        if (w_start_edge) w_next_state = ST_IDLE;
      end
      // Codes 5..7 are unreachable in normal operation; recover to IDLE.
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_enter_run    = (r_state == ST_IDLE) && (w_next_state == ST_RUN);
  assign w_enter_crash  = (r_state != ST_CRASH) && (w_next_state == ST_CRASH);
  assign w_enter_finish = (r_state == ST_RUN) && (w_next_state == ST_FINISH);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_start_q     <= 1'b1;
      r_pause_q     <= 1'b1;
      r_hold_cnt    <= 4'd0;
      r_reset_game  <= 1'b0;
      r_finish_time <= '0;
    end else begin
      r_state      <= w_next_state;
      r_start_q    <= start_btn;
      r_pause_q    <= pause_btn;
      // Pulse lands on the first RUN cycle of a new game, not on resume.
      r_reset_game <= w_enter_run;

      // The exiting tick may leave the counter unwrapped; entry clears it.
      if (w_enter_crash)
        r_hold_cnt <= 4'd0;
      else if ((r_state == ST_CRASH) && second_tick)
        r_hold_cnt <= r_hold_cnt + 4'd1;

      if (w_enter_run)
        r_finish_time <= '0;
      else if (w_enter_finish)
        r_finish_time <= run_time;
    end
  end

  // Moore decode of the state register.
  assign start_en    = (r_state == ST_IDLE);
  assign crash_en    = (r_state == ST_CRASH);
  assign finish_en   = (r_state == ST_FINISH);
  assign pause       = (r_state != ST_RUN);
  // Held high for the whole reset so the timer is cleared alongside us.
  assign reset_game  = r_reset_game | reset;
  assign finish_time = r_finish_time;
  assign state       = r_state;

endmodule
